// File: rtl/chnl_slave_fifo_if.sv
// Channel write port and arbiter pop port of one MCDT slave FIFO.
// Signal names keep the direction as seen from the FIFO (slave modport).
interface chnl_slave_fifo_if #(
   parameter int DATA_W   = 32,
   parameter int MARGIN_W = 6
);
   logic [DATA_W-1:0]   ch_data_i;
   logic                ch_valid_i;
   logic                ch_ready_o;
   logic [MARGIN_W-1:0] ch_margin_o;
   logic                slv_en_i;
   logic                a2s_ack_i;
   logic                slv_req_o;
   logic [DATA_W-1:0]   slv_data_o;
   logic [MARGIN_W-1:0] slv_count_o;
   logic                slv_ovf_o;
   logic                slv_udf_o;

   modport slave (
      input  ch_data_i, ch_valid_i, slv_en_i, a2s_ack_i,
      output ch_ready_o, ch_margin_o, slv_req_o, slv_data_o,
      output slv_count_o, slv_ovf_o, slv_udf_o
   );

   modport master (
      output ch_data_i, ch_valid_i, slv_en_i, a2s_ack_i,
      input  ch_ready_o, ch_margin_o, slv_req_o, slv_data_o,
      input  slv_count_o, slv_ovf_o, slv_udf_o
   );
endinterface

// File: rtl/chnl_slave_fifo.sv
// Per-channel first-word-fall-through FIFO at the front of the MCDT datapath.
// Ready/req come from registered count only; sticky overflow/underflow flags.
module chnl_slave_fifo #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int MARGIN_W = 6
) (
   input logic              clk_i,
   input logic              rst_i,
   chnl_slave_fifo_if.slave bus
);
   localparam logic [MARGIN_W-1:0] FULL_CNT = MARGIN_W'(DEPTH);
   localparam logic [MARGIN_W-1:0] ONE      = MARGIN_W'(1);

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [MARGIN_W-1:0] count;
   logic [MARGIN_W-1:0] margin;
   logic                ovf;
   logic                udf;
   logic                full;
   logic                empty;
   logic                ready;
   logic                req;
   logic                push;
   logic                pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign ready = bus.slv_en_i & ~full & ~rst_i;
   assign req   = bus.slv_en_i & ~empty;
   assign push  = bus.ch_valid_i & ready;
   assign pop   = bus.a2s_ack_i & req;

   assign bus.ch_ready_o  = ready;
   assign bus.ch_margin_o = margin;
   assign bus.slv_req_o   = req;
   assign bus.slv_count_o = count;
   assign bus.slv_ovf_o   = ovf;
   assign bus.slv_udf_o   = udf;
   // Head word is forced to zero when empty so reset shows a clean bus
   assign bus.slv_data_o  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= bus.ch_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count  <= '0;
         margin <= FULL_CNT;
      end else if (push && !pop) begin
         count  <= count + ONE;
         margin <= margin - ONE;
      end else if (pop && !push) begin
         count  <= count - ONE;
         margin <= margin + ONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (bus.ch_valid_i && bus.slv_en_i && full) begin
            ovf <= 1'b1;
         end
         if (bus.a2s_ack_i && !req) begin
            udf <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_chnl_slave_fifo.sv
// Randomized and directed bench for chnl_slave_fifo against a queue model.
// Inputs change on the falling edge; outputs are checked just after it.
module tb_chnl_slave_fifo;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   logic [31:0] q[$];
   bit          m_ovf;
   bit          m_udf;
   int unsigned seqn;

   always #5 clk = ~clk;

   chnl_slave_fifo_if #(.DATA_W(32), .MARGIN_W(6)) bus ();

   chnl_slave_fifo dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_ready", 32'(bus.ch_ready_o), 0);
      chk("rst_margin", 32'(bus.ch_margin_o), DEPTH);
      chk("rst_req", 32'(bus.slv_req_o), 0);
      chk("rst_data", bus.slv_data_o, 0);
      chk("rst_count", 32'(bus.slv_count_o), 0);
      chk("rst_ovf", 32'(bus.slv_ovf_o), 0);
      chk("rst_udf", 32'(bus.slv_udf_o), 0);
   endtask

   // One clock: drive, check against model state, advance model.
   task automatic step(input bit v, input logic [31:0] d, input bit a,
                       input bit e, output bit pushed);
      int  sz;
      bit  rdy;
      bit  req;
      @(negedge clk);
      bus.ch_valid_i = v;
      bus.ch_data_i  = d;
      bus.a2s_ack_i  = a;
      bus.slv_en_i   = e;
      #1;
      sz  = q.size();
      rdy = e && (sz < DEPTH);
      req = e && (sz > 0);
      chk("ready", 32'(bus.ch_ready_o), 32'(rdy));
      chk("req", 32'(bus.slv_req_o), 32'(req));
      chk("margin", 32'(bus.ch_margin_o), 32'(DEPTH - sz));
      chk("count", 32'(bus.slv_count_o), 32'(sz));
      chk("ovf", 32'(bus.slv_ovf_o), 32'(m_ovf));
      chk("udf", 32'(bus.slv_udf_o), 32'(m_udf));
      if (req) chk("data", bus.slv_data_o, q[0]);
      if (v && e && sz == DEPTH) m_ovf = 1'b1;
      if (a && !req) m_udf = 1'b1;
      if (a && req) void'(q.pop_front());
      pushed = v && rdy;
      if (pushed) q.push_back(d);
   endtask

   task automatic flush_model();
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic drain();
      bit p;
      for (int i = 0; i < 40 && q.size() > 0; i++) step(0, 0, 1, 1, p);
   endtask

   initial begin
      bit p;
      bus.ch_valid_i = 1'b0;
      bus.ch_data_i  = '0;
      bus.a2s_ack_i  = 1'b0;
      bus.slv_en_i   = 1'b1;
      flush_model();
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      @(negedge clk);
      rst = 1'b0;

      repeat (2) step(0, 0, 0, 1, p);

      for (int i = 0; i < 5; i++) step(1, 32'h00C00000 + i, 0, 1, p);
      step(0, 0, 0, 1, p);
      chk("burst_count", 32'(bus.slv_count_o), 5);
      chk("burst_margin", 32'(bus.ch_margin_o), 27);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 1, p);
      step(0, 0, 0, 1, p);

      for (int i = 0; i < DEPTH + 1; i++)
         step(1, 32'h00B00000 + i, 0, 1, p);
      chk("full_count", 32'(bus.slv_count_o), DEPTH);
      step(0, 0, 1, 1, p);
      step(0, 0, 0, 1, p);
      chk("after_ack_margin", 32'(bus.ch_margin_o), 1);

      seqn = 0;
      step(1, 32'h00C10000 + seqn, 0, 1, p);
      if (p) seqn++;
      for (int i = 0; i < 100; i++) begin
         step(1, 32'h00C10000 + seqn, 1, 1, p);
         if (p) seqn++;
      end
      drain();

      for (int i = 0; i < 10; i++) step(1, 32'h00D00000 + i, 0, 1, p);
      for (int i = 0; i < 64; i++) step(1, 32'h00D10000 + i, 1, 1, p);
      step(0, 0, 0, 1, p);
      chk("steady_count", 32'(bus.slv_count_o), 10);
      drain();

      for (int i = 0; i < 3; i++) step(1, 32'h00E00000 + i, 0, 1, p);
      for (int i = 0; i < 4; i++) step(1, 32'h00EF0000, 1, 0, p);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 1, p);
      step(0, 0, 0, 1, p);
      chk("en_udf", 32'(bus.slv_udf_o), 1);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) != 0, p);

      for (int i = 0; i < 6; i++) step(1, 32'h00F00000 + i, 0, 1, p);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      flush_model();
      chk_reset();
      @(negedge clk);
      bus.ch_valid_i = 1'b0;
      rst = 1'b0;
      repeat (2) step(0, 0, 0, 1, p);
      step(1, 32'h00A0A0A0, 0, 1, p);
      step(0, 0, 1, 1, p);
      step(0, 0, 0, 1, p);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
